// File: rtl/tm1638_pkg.sv
// Shared definitions for the TM1638 key filter slice.
//   NUM_KEYS     : number of raw key bits delivered by the TM1638 scan driver
//   key_state_e  : per-key debounce FSM states
//   cnt_width()  : counter width needed to hold a count up to a given value
//   max3()       : largest of three parameter values, used to size counters
package tm1638_pkg;

  localparam int unsigned NUM_KEYS = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } key_state_e;

  function automatic int unsigned cnt_width(input int unsigned value);
    int unsigned w;
    if (value < 32'd2) begin
      w = 1;
    end else begin
      w = $clog2(value + 32'd1);
    end
    return w;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/tm1638_key_cell.sv
// One key of the TM1638 key filter: 2-flop input synchroniser, debounce FSM,
// debounce counter and auto-repeat counters.
// Ports:
//   clk         in  system clock (TM1638 driver domain)
//   rst_n       in  asynchronous active-low reset
//   sw_raw      in  raw key bit from the scan driver
//   key_level   out debounced level, 1 = pressed
//   key_press   out 1-cycle pulse on accepted press edge and on each repeat event
//   key_release out 1-cycle pulse on accepted release edge
//   press_edge  out 1-cycle pulse on accepted press edge only (no repeats)
module tm1638_key_cell
  import tm1638_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic press_edge
);

  localparam int unsigned CW = cnt_width(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
  localparam bit            REPEAT_EN = (REPEAT_DELAY != 0);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] REP_SAT   = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST  = CW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] ONE       = CW'(1);

  logic          sync_q1, sync_q2;
  key_state_e    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] rep_cnt, rep_n;
  logic [CW-1:0] per_cnt, per_n;
  logic          level_q, level_n;
  logic          press_q, press_n;
  logic          release_q, release_n;
  logic          edge_q, edge_n;

  // Kept even though the driver shares clk: it isolates the FSM from the
  // driver's register timing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= sw_raw;
      sync_q2 <= sync_q1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rep_cnt   <= '0;
      per_cnt   <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      edge_q    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      rep_cnt   <= rep_n;
      per_cnt   <= per_n;
      level_q   <= level_n;
      press_q   <= press_n;
      release_q <= release_n;
      edge_q    <= edge_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rep_n     = rep_cnt;
    per_n     = per_cnt;
    level_n   = level_q;
    press_n   = 1'b0;
    release_n = 1'b0;
    edge_n    = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync_q2) begin
          state_n = ARMING;
          cnt_n   = ONE;
        end
      end
      ARMING: begin
        if (!sync_q2) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n = PRESSED;
          cnt_n   = '0;
          level_n = 1'b1;
          press_n = 1'b1;
          edge_n  = 1'b1;
          rep_n   = '0;
          per_n   = '0;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      PRESSED: begin
        if (!sync_q2) begin
          state_n = RELEASING;
          cnt_n   = ONE;
        end else if (REPEAT_EN) begin
          // rep_cnt counts up to REPEAT_DELAY and parks there; once parked,
          // per_cnt alone paces the later repeat pulses.
          if (rep_cnt < REP_SAT) begin
            rep_n = rep_cnt + ONE;
            if (rep_cnt == REP_LAST) begin
              press_n = 1'b1;
              per_n   = '0;
            end
          end else if (per_cnt == PER_LAST) begin
            press_n = 1'b1;
            per_n   = '0;
          end else begin
            per_n = per_cnt + ONE;
          end
        end
      end
      RELEASING: begin
        // Repeat counters are frozen here so a release bounce resumes the
        // repeat phase where it left off.
        if (sync_q2) begin
          state_n = PRESSED;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n   = IDLE;
          cnt_n     = '0;
          level_n   = 1'b0;
          release_n = 1'b1;
        end else begin
          cnt_n = cnt + ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign press_edge  = edge_q;

endmodule

// File: rtl/tm1638_key_filter.sv
// TM1638 key filter: turns the eight raw scan bits into debounced levels,
// press/release pulses and auto-repeat press pulses, one key cell per bit.
// Optional feature macro: TM1638_KEY_TOGGLE_EN builds per-key toggle latches
// that invert on every debounced press edge; otherwise key_toggle is 0.
// Ports:
//   clk         in   system clock, same clk as the TM1638 driver
//   rst_n       in   asynchronous active-low reset
//   sw_raw      in   raw key bits, bit i = sw<i>
//   key_level   out  debounced key state, 1 = pressed
//   key_press   out  1-cycle pulse per accepted press edge and repeat event
//   key_release out  1-cycle pulse per accepted release edge
//   key_toggle  out  per-key toggle latch (0 unless the macro is defined)
//   any_key     out  OR of key_level
module tm1638_key_filter
  import tm1638_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_KEYS-1:0] sw_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_toggle,
  output logic                any_key
);

  logic [NUM_KEYS-1:0] press_edge;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    tm1638_key_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .sw_raw     (sw_raw[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .press_edge (press_edge[i])
    );
  end

  assign any_key = |key_level;

`ifdef TM1638_KEY_TOGGLE_EN
  logic [NUM_KEYS-1:0] toggle_q;

  // press_edge excludes repeat pulses, so holding a key never re-toggles it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q <= '0;
    end else begin
      toggle_q <= toggle_q ^ press_edge;
    end
  end

  assign key_toggle = toggle_q;
`else
  logic unused_press_edge;

  assign unused_press_edge = ^press_edge;
  assign key_toggle        = '0;
`endif

endmodule

// File: tb/tb_tm1638_key_filter.sv
module tb_tm1638_key_filter;

  typedef struct {
    int         cyc;
    logic [7:0] press;
    logic [7:0] rel;
    logic [7:0] level;
    string      tag;
  } exp_t;

`ifdef TM1638_KEY_TOGGLE_EN
  localparam logic TOG_ON = 1'b1;
`else
  localparam logic TOG_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] sw_raw = 8'h00;
  logic [7:0] key_level, key_press, key_release, key_toggle;
  logic       any_key;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  exp_t mon_e;

  tm1638_key_filter #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_raw     (sw_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_toggle (key_toggle),
    .any_key    (any_key)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: at every falling edge either the head event is due and
  // is compared in full, or no pulse of any kind may be present.
  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].cyc < cyc) begin
      mon_e = sb.pop_front();
      vectors++;
      assert (mon_e.cyc >= cyc) else begin
        miscompares++;
        $error("FAIL %s: event due at cycle %0d not seen (now %0d)", mon_e.tag, mon_e.cyc, cyc);
      end
    end
    if (sb.size() != 0 && sb[0].cyc == cyc) begin
      mon_e = sb.pop_front();
      vectors++;
      assert ({key_press, key_release, key_level, any_key} ===
              {mon_e.press, mon_e.rel, mon_e.level, (mon_e.level != 8'h00)}) else begin
        miscompares++;
        $error("FAIL %s: observed press=%h rel=%h level=%h any=%b expected press=%h rel=%h level=%h",
               mon_e.tag, key_press, key_release, key_level, any_key,
               mon_e.press, mon_e.rel, mon_e.level);
      end
    end else begin
      vectors++;
      assert ({key_press, key_release} === 16'h0000) else begin
        miscompares++;
        $error("FAIL no_pulse@%0d: observed press=%h rel=%h expected 00 00",
               cyc, key_press, key_release);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic expect_ev(input int c, input logic [7:0] p, input logic [7:0] r,
                           input logic [7:0] l, input string tag);
    exp_t e;
    e.cyc   = c;
    e.press = p;
    e.rel   = r;
    e.level = l;
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int c, a, d, f, r;
    rst_n = 1'b0;
    step();
    step();
    check("reset_outputs", {key_level, key_press, key_release, key_toggle, any_key}, 64'h0);
    rst_n = 1'b1;
    step();
    step();

    // 1. Clean press of key 0, released before any repeat.
    c = cyc;
    sw_raw = 8'h01;
    expect_ev(c + 6, 8'h01, 8'h00, 8'h01, "clean_press");
    wait_until(c + 10);
    d = cyc;
    sw_raw = 8'h00;
    expect_ev(d + 6, 8'h00, 8'h01, 8'h00, "clean_release");
    wait_until(d + 10);

    // 2. Three-cycle glitch on key 3 is one short of the debounce window.
    c = cyc;
    sw_raw = 8'h08;
    wait_until(c + 3);
    sw_raw = 8'h00;
    wait_until(c + 12);
    check("glitch_level", {56'h0, key_level}, 64'h0);

    // 3. Bounce on release of key 2: 0,1,0 at two-cycle spacing.
    c = cyc;
    sw_raw = 8'h04;
    expect_ev(c + 6, 8'h04, 8'h00, 8'h04, "bounce_press");
    wait_until(c + 8);
    sw_raw = 8'h00;
    wait_until(c + 10);
    sw_raw = 8'h04;
    wait_until(c + 12);
    f = cyc;
    sw_raw = 8'h00;
    expect_ev(f + 6, 8'h00, 8'h04, 8'h00, "bounce_release");
    wait_until(f + 10);

    // 4. Auto-repeat on key 7; raw drops 36 cycles after acceptance.
    c = cyc;
    a = c + 6;
    sw_raw = 8'h80;
    expect_ev(a,      8'h80, 8'h00, 8'h80, "repeat_edge");
    expect_ev(a + 20, 8'h80, 8'h00, 8'h80, "repeat_first");
    expect_ev(a + 25, 8'h80, 8'h00, 8'h80, "repeat_p1");
    expect_ev(a + 30, 8'h80, 8'h00, 8'h80, "repeat_p2");
    expect_ev(a + 35, 8'h80, 8'h00, 8'h80, "repeat_p3");
    wait_until(a + 36);
    sw_raw = 8'h00;
    expect_ev(a + 42, 8'h00, 8'h80, 8'h00, "repeat_release");
    wait_until(a + 46);

    // 5. Four keys together, then a one-cycle reset while held.
    c = cyc;
    sw_raw = 8'hA5;
    expect_ev(c + 6, 8'hA5, 8'h00, 8'hA5, "multi_press");
    wait_until(c + 8);
    check("multi_any_key", {63'h0, any_key}, 64'h1);
    wait_until(c + 9);
    rst_n = 1'b0;
    #1;
    check("reset_async", {key_level, key_press, key_release, key_toggle, any_key}, 64'h0);
    step();
    rst_n = 1'b1;
    r = cyc;
    expect_ev(r + 6, 8'hA5, 8'h00, 8'hA5, "fresh_press");
    wait_until(r + 8);
    sw_raw = 8'h00;
    expect_ev(r + 14, 8'h00, 8'hA5, 8'h00, "fresh_release");
    wait_until(r + 18);

    // 6. Key 1 pressed twice, held through repeats each time.
    for (int round = 0; round < 2; round++) begin
      logic tog_exp;
      tog_exp = (round == 0) ? TOG_ON : 1'b0;
      c = cyc;
      a = c + 6;
      sw_raw = 8'h02;
      expect_ev(a,      8'h02, 8'h00, 8'h02, "toggle_edge");
      expect_ev(a + 20, 8'h02, 8'h00, 8'h02, "toggle_rep1");
      expect_ev(a + 25, 8'h02, 8'h00, 8'h02, "toggle_rep2");
      wait_until(a + 2);
      check("toggle_after_press", {63'h0, key_toggle[1]}, {63'h0, tog_exp});
      wait_until(a + 27);
      check("toggle_after_repeat", {63'h0, key_toggle[1]}, {63'h0, tog_exp});
      sw_raw = 8'h00;
      expect_ev(a + 33, 8'h00, 8'h02, 8'h00, "toggle_release");
      wait_until(a + 36);
      check("toggle_after_release", {63'h0, key_toggle[1]}, {63'h0, tog_exp});
    end

    for (int k = 0; k < 60 && sb.size() != 0; k++) step();
    vectors++;
    assert (sb.size() == 0) else begin
      miscompares += sb.size();
      $error("FAIL scoreboard_drain: observed %0d outstanding expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
